init_command_word_sequencer: RTL and testbench
==============================================

// Module: init_command_word_sequencer
// PURPOSE
//  Clocked, parametrised successor to the ICW4 decoder. Owns the complete 8259A init sequence
//  (ICW1 -> ICW2 -> ICW3? -> ICW4? -> READY) and holds every ICW field in a true register.
//  Resolves master/slave and the SP/EN buffer-enable function. Gates data-port writes into OCW1
//  once initialisation is done. Sits between the read/write decode and the control logic.
// PARAMETERS
//  IR_COUNT      8  number of IR/cascade lines carried in ICW3 (1..8)
//  CAS_ID_WIDTH  3  width of slave ID field in ICW3 (1..3)
//  VECTOR_LSB    3  lowest ICW2 bit kept as vector base in 8086 mode (bits below from IR)
// PORTS
//  clock                       in   1  system clock, all state on rising edge
//  reset                       in   1  asynchronous, active-high
//  write_initial_command_word_1 in  1  decoded ICW1 strobe (A0=0, D4=1), one cycle per write
//  write_data_port             in   1  decoded A0=1 write strobe, one cycle per write
//  internal_data_bus           in   8  write data, sampled with strobes
//  slave_program_n_pin         in   1  level on SP/EN pin when not buffered (1=master)
//  level_or_edge_config        out  1  ICW1.LTIM
//  address_interval_config     out  1  ICW1.ADI
//  single_or_cascade_config    out  1  ICW1.SNGL
//  vector_base                 out  8  ICW2 value; bits below VECTOR_LSB forced 0 when uPM=1
//  cascade_device_config       out  IR_COUNT  ICW3 as master: slave-present mask
//  slave_id                    out  CAS_ID_WIDTH  ICW3[CAS_ID_WIDTH-1:0] as slave
//  special_fully_nest_config   out  1  ICW4.SFNM
//  buffered_mode_config        out  1  ICW4.BUF
//  buffered_master_or_slave_config out 1  ICW4.M/S
//  auto_eoi_config             out  1  ICW4.AEOI
//  u8086_or_mcs80_config       out  1  ICW4.uPM
//  is_master                   out  1  BUF ? M/S : slave_program_n_pin (combinational)
//  buffer_enable               out  1  BUF ? 1 : 0; drive SP/EN pin as output when high
//  init_done                   out  1  high in READY
//  write_operation_control_word_1 out 1  = write_data_port & READY & ~ICW1 strobe (combinational)
// BEHAVIOUR
//  States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY. Reset -> UNINIT.
//  Reset: every config output, vector_base, ICW3 fields = 0; init_done = 0.
//  ICW1 strobe, any state: latch LTIM=D3, ADI=D2, SNGL=D1, IC4=D0 (internal).
//   Same edge: clear ICW2, ICW3 and all ICW4 fields to 0; go to WAIT_ICW2; init_done -> 0.
//  ICW1 has priority when both strobes are high in one cycle; the data write is ignored.
//  WAIT_ICW2 + data write: capture ICW2. Next state:
//   WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY.
//  WAIT_ICW3 + data write: capture ICW3. Next state: WAIT_ICW4 if IC4=1, else READY.
//   cascade_device_config = bus[IR_COUNT-1:0].
//   slave_id = bus[CAS_ID_WIDTH-1:0].
//  WAIT_ICW4 + data write: capture bus[4:0] into SFNM/BUF/MS/AEOI/uPM. Next state: READY.
//   Bits 7:5 are ignored.
//  IC4=0 path: ICW4 fields stay 0 (uPM=0, MCS-80 mode).
//  READY + data write: no register change; write_operation_control_word_1 pulses for that cycle.
//  Data writes in UNINIT are dropped; no pulse.
//  Latency: captured fields and init_done are visible the cycle after the strobe edge.
//  Stalled sequence: strobes absent -> state holds indefinitely. No timeout.
//  reset asserted mid-sequence: immediate return to UNINIT with reset values.
//   No partial fields survive.
//  vector_base uPM masking is applied at the output; the stored ICW2 is unmasked.
//   Toggling uPM via a new sequence therefore re-masks consistently.
// TESTING
//  ICW1=0x13, ICW2=0x20, ICW4=0x03 -> 3 steps, no ICW3.
//   init_done on cycle after ICW4; vector_base=0x20; AEOI=1; uPM=1; cascade_device_config=0.
//  ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x0D -> cascade_device_config=0x04; SFNM=0.
//   BUF=1, MS=1, buffer_enable=1, is_master=1.
//  ICW1=0x12, ICW2=0x40 -> READY after ICW2; all ICW4 fields 0.
//   Then data write 0xFF -> one-cycle write_operation_control_word_1, no field change.
//  Full init with ICW4=0x1F, then ICW1=0x11 -> ICW4 fields clear.
//   init_done=0 and state WAIT_ICW2 on the next cycle.
//  ICW1 and data strobe in the same cycle -> ICW1 taken, bus not captured as ICW2.
//  reset pulsed between ICW2 and ICW3 -> all outputs 0, state UNINIT.
//   A later data write is dropped.
//  Non-buffered, uPM=1, ICW2=0x27 -> vector_base=0x20.
//   slave_program_n_pin 0/1 -> is_master follows it.

Source files
------------

// File: rtl/init_command_word_sequencer.sv
// init_command_word_sequencer
//   Owns the 8259A initialisation sequence (ICW1 -> ICW2 -> ICW3? -> ICW4? -> READY).
//   It holds every ICW field in a register and resolves master/slave and the SP/EN
//   buffer-enable function. Once initialisation is complete, it forwards data-port
//   writes as OCW1 strobes.
// Ports
//   clock, reset                     rising-edge clock, async active-high reset
//   write_initial_command_word_1     decoded ICW1 strobe (one cycle per write)
//   write_data_port                  decoded A0=1 write strobe (one cycle per write)
//   internal_data_bus[7:0]           write data, sampled with the strobes
//   slave_program_n_pin              SP/EN pin level when not buffered (1 = master)
//   level_or_edge_config / address_interval_config / single_or_cascade_config
//                                    ICW1 LTIM / ADI / SNGL
//   vector_base[7:0]                 ICW2; low bits forced to 0 in 8086 mode
//   cascade_device_config, slave_id  ICW3 read as master mask / slave id
//   special_fully_nest_config, buffered_mode_config, buffered_master_or_slave_config,
//   auto_eoi_config, u8086_or_mcs80_config
//                                    ICW4 SFNM / BUF / M/S / AEOI / uPM
//   is_master, buffer_enable         resolved SP/EN function
//   init_done                        high while in READY
//   write_operation_control_word_1   data-port write accepted as OCW1 this cycle
module init_command_word_sequencer #(
  parameter int IR_COUNT     = 8,
  parameter int CAS_ID_WIDTH = 3,
  parameter int VECTOR_LSB   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_initial_command_word_1,
  input  logic                    write_data_port,
  input  logic [7:0]              internal_data_bus,
  input  logic                    slave_program_n_pin,
  output logic                    level_or_edge_config,
  output logic                    address_interval_config,
  output logic                    single_or_cascade_config,
  output logic [7:0]              vector_base,
  output logic [IR_COUNT-1:0]     cascade_device_config,
  output logic [CAS_ID_WIDTH-1:0] slave_id,
  output logic                    special_fully_nest_config,
  output logic                    buffered_mode_config,
  output logic                    buffered_master_or_slave_config,
  output logic                    auto_eoi_config,
  output logic                    u8086_or_mcs80_config,
  output logic                    is_master,
  output logic                    buffer_enable,
  output logic                    init_done,
  output logic                    write_operation_control_word_1
);

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  // Bits of ICW2 that come from the IR number in 8086 mode.
  localparam logic [7:0] LOW_MASK = 8'((16'd1 << VECTOR_LSB) - 16'd1);

  state_t                  state;
  logic                    ic4;
  logic                    ltim, adi, sngl;
  logic [7:0]              icw2;
  logic [IR_COUNT-1:0]     cas_mask;
  logic [CAS_ID_WIDTH-1:0] cas_id;
  logic                    sfnm, bufm, ms, aeoi, upm;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= UNINIT;
      ic4      <= 1'b0;
      ltim     <= 1'b0;
      adi      <= 1'b0;
      sngl     <= 1'b0;
      icw2     <= '0;
      cas_mask <= '0;
      cas_id   <= '0;
      sfnm     <= 1'b0;
      bufm     <= 1'b0;
      ms       <= 1'b0;
      aeoi     <= 1'b0;
      upm      <= 1'b0;
    end else if (write_initial_command_word_1) begin
      // ICW1 restarts the sequence from any state and wins over a same-cycle data write.
      ltim     <= internal_data_bus[3];
      adi      <= internal_data_bus[2];
      sngl     <= internal_data_bus[1];
      ic4      <= internal_data_bus[0];
      icw2     <= '0;
      cas_mask <= '0;
      cas_id   <= '0;
      sfnm     <= 1'b0;
      bufm     <= 1'b0;
      ms       <= 1'b0;
      aeoi     <= 1'b0;
      upm      <= 1'b0;
      state    <= WAIT_ICW2;
    end else if (write_data_port) begin
      case (state)
        WAIT_ICW2: begin
          icw2 <= internal_data_bus;
          if (!sngl)    state <= WAIT_ICW3;
          else if (ic4) state <= WAIT_ICW4;
          else          state <= READY;
        end
        WAIT_ICW3: begin
          cas_mask <= internal_data_bus[IR_COUNT-1:0];
          cas_id   <= internal_data_bus[CAS_ID_WIDTH-1:0];
          state    <= ic4 ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: begin
          sfnm  <= internal_data_bus[4];
          bufm  <= internal_data_bus[3];
          ms    <= internal_data_bus[2];
          aeoi  <= internal_data_bus[1];
          upm   <= internal_data_bus[0];
          state <= READY;
        end
        default: ; // UNINIT drops the write; READY routes it to OCW1 below
      endcase
    end
  end

  assign level_or_edge_config            = ltim;
  assign address_interval_config         = adi;
  assign single_or_cascade_config        = sngl;
  // Stored ICW2 stays unmasked so that a later uPM change re-masks consistently.
  assign vector_base                     = upm ? (icw2 & ~LOW_MASK) : icw2;
  assign cascade_device_config           = cas_mask;
  assign slave_id                        = cas_id;
  assign special_fully_nest_config       = sfnm;
  assign buffered_mode_config            = bufm;
  assign buffered_master_or_slave_config = ms;
  assign auto_eoi_config                 = aeoi;
  assign u8086_or_mcs80_config           = upm;

  // In buffered mode SP/EN becomes an output, so the role comes from ICW4 M/S.
  assign is_master     = bufm ? ms : slave_program_n_pin;
  assign buffer_enable = bufm;

  assign init_done = (state == READY);
  assign write_operation_control_word_1 =
    write_data_port & (state == READY) & ~write_initial_command_word_1;

endmodule

// File: tb/tb_init_command_word_sequencer.sv
module tb_init_command_word_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       icw1_wr, data_wr;
  logic [7:0] bus;
  logic       spn;

  logic       ltim, adi, sngl, sfnm, bufm, ms, aeoi, upm;
  logic [7:0] vb, cas;
  logic [2:0] sid;
  logic       im, be, done, wo;

  init_command_word_sequencer #(.IR_COUNT(8), .CAS_ID_WIDTH(3), .VECTOR_LSB(3)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .write_initial_command_word_1    (icw1_wr),
    .write_data_port                 (data_wr),
    .internal_data_bus               (bus),
    .slave_program_n_pin             (spn),
    .level_or_edge_config            (ltim),
    .address_interval_config         (adi),
    .single_or_cascade_config        (sngl),
    .vector_base                     (vb),
    .cascade_device_config           (cas),
    .slave_id                        (sid),
    .special_fully_nest_config       (sfnm),
    .buffered_mode_config            (bufm),
    .buffered_master_or_slave_config (ms),
    .auto_eoi_config                 (aeoi),
    .u8086_or_mcs80_config           (upm),
    .is_master                       (im),
    .buffer_enable                   (be),
    .init_done                       (done),
    .write_operation_control_word_1  (wo)
  );

  always #5 clock = ~clock;

  // cfg = {LTIM, ADI, SNGL, SFNM, BUF, M/S, AEOI, uPM}
  typedef struct packed {
    logic       done;
    logic [7:0] vb;
    logic [7:0] cfg;
    logic [7:0] cas;
    logic [2:0] sid;
    logic       im;
    logic       be;
  } obs_t;

  typedef struct {
    logic       i1;
    logic       dw;
    logic [7:0] bus;
    logic       spn;
    logic       wo;
    obs_t       exp;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  vec_t tbl[$];

  function automatic obs_t observe();
    obs_t o;
    o.done = done;
    o.vb   = vb;
    o.cfg  = {ltim, adi, sngl, sfnm, bufm, ms, aeoi, upm};
    o.cas  = cas;
    o.sid  = sid;
    o.im   = im;
    o.be   = be;
    return o;
  endfunction

  function automatic vec_t mk(logic i1, logic dw, logic [7:0] b, logic sp, logic w,
                              logic d, logic [7:0] v, logic [7:0] cfg, logic [7:0] c,
                              logic [2:0] s, logic m, logic e);
    vec_t r;
    r.i1  = i1;
    r.dw  = dw;
    r.bus = b;
    r.spn = sp;
    r.wo  = w;
    r.exp = '{done: d, vb: v, cfg: cfg, cas: c, sid: s, im: m, be: e};
    return r;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t got;
    got = observe();
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got done=%0b vb=%02h cfg=%02h cas=%02h sid=%0d im=%0b be=%0b, want done=%0b vb=%02h cfg=%02h cas=%02h sid=%0d im=%0b be=%0b",
               name, got.done, got.vb, got.cfg, got.cas, got.sid, got.im, got.be,
               exp.done, exp.vb, exp.cfg, exp.cas, exp.sid, exp.im, exp.be);
    end
  endtask

  task automatic check_wo(input string name, input logic exp);
    n_vec++;
    if (wo !== exp) begin
      n_err++;
      $display("FAIL %s ocw1 strobe: got %0b want %0b", name, wo, exp);
    end
  endtask

  // One cycle: drive on the falling edge, check the combinational strobe,
  // queue the post-edge expectation, then pop and compare after the rising edge.
  task automatic apply(input string name, input vec_t v);
    @(negedge clock);
    icw1_wr = v.i1;
    data_wr = v.dw;
    bus     = v.bus;
    spn     = v.spn;
    #1;
    check_wo(name, v.wo);
    exp_q.push_back(v.exp);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check_obs(name, exp_q.pop_front());
    end
    icw1_wr = 1'b0;
    data_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; icw1_wr = 1'b0; data_wr = 1'b0; bus = 8'h00; spn = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_obs("reset_state", '{done: 0, vb: 0, cfg: 0, cas: 0, sid: 0, im: 1, be: 0});

    //         i1 dw bus    sp wo  done vb     cfg    cas    sid  im be
    // ICW1 0x13 / ICW2 0x20 / ICW4 0x03 : single, no ICW3
    tbl.push_back(mk(1, 0, 8'h13, 1, 0, 0, 8'h00, 8'h20, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h20, 1, 0, 0, 8'h20, 8'h20, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h03, 1, 0, 1, 8'h20, 8'h23, 8'h00, 0, 1, 0));
    // ICW1 0x11 / 0x08 / ICW3 0x04 / ICW4 0x0D : cascade, buffered master
    tbl.push_back(mk(1, 0, 8'h11, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h08, 1, 0, 0, 8'h08, 8'h00, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h04, 1, 0, 0, 8'h08, 8'h00, 8'h04, 4, 1, 0));
    tbl.push_back(mk(0, 1, 8'h0D, 1, 0, 1, 8'h08, 8'h0D, 8'h04, 4, 1, 1));
    // ICW1 0x12 / ICW2 0x40 : ready after ICW2, then OCW1 write
    tbl.push_back(mk(1, 0, 8'h12, 1, 0, 0, 8'h00, 8'h20, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h40, 1, 0, 1, 8'h40, 8'h20, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 1, 1, 8'h40, 8'h20, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 1, 8'h40, 8'h20, 8'h00, 0, 1, 0));
    // ICW1 and data strobe together in READY: ICW1 wins, no OCW1 pulse
    tbl.push_back(mk(1, 1, 8'h1B, 1, 0, 0, 8'h00, 8'hA0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h27, 1, 0, 0, 8'h27, 8'hA0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h1F, 1, 0, 1, 8'h20, 8'hBF, 8'h00, 0, 1, 1));
    // New ICW1 after full init clears the ICW4 fields
    tbl.push_back(mk(1, 0, 8'h11, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h27, 1, 0, 0, 8'h27, 8'h00, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 8'h27, 8'h00, 8'hFF, 7, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1, 0, 1, 8'h20, 8'h01, 8'hFF, 7, 1, 0));
    // Non-buffered: is_master follows the pin
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h20, 8'h01, 8'hFF, 7, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h20, 8'h01, 8'hFF, 7, 1, 0));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Reset between ICW2 and ICW3, then a dropped data write in UNINIT
    apply("rst_icw1", mk(1, 0, 8'h11, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    apply("rst_icw2", mk(0, 1, 8'h08, 1, 0, 0, 8'h08, 8'h00, 8'h00, 0, 1, 0));
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_obs("rst_async", '{done: 0, vb: 0, cfg: 0, cas: 0, sid: 0, im: 1, be: 0});
    #1 reset = 1'b0;
    apply("uninit_drop", mk(0, 1, 8'h55, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0));
    // Stall: no strobes, state holds in UNINIT
    apply("uninit_hold", mk(0, 0, 8'h55, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
